// File: rtl/bypass_tracker_pkg.sv
// Shared types and constants for the issue-stage operand bypass tracker.
// Entry/readout widths follow the default pipeline geometry below.
package bypass_tracker_pkg;

  localparam int BT_ISSUE_W = 2;
  localparam int BT_STAGES  = 5;
  localparam int BT_REG_AW  = 5;
  localparam int BT_DATA_W  = 32;
  localparam int BT_STG_W   = $clog2(BT_STAGES + 1);

  // First stage index at which a producer's result can be forwarded.
  localparam logic [BT_STG_W-1:0] RDY_ALU   = BT_STG_W'(0);
  localparam logic [BT_STG_W-1:0] RDY_HILO  = BT_STG_W'(1);
  localparam logic [BT_STG_W-1:0] RDY_MEM   = BT_STG_W'(2);
  localparam logic [BT_STG_W-1:0] RDY_NEVER = BT_STG_W'(BT_STAGES);

  typedef struct packed {
    logic                valid;
    logic [BT_REG_AW-1:0] rdst;
    logic [BT_STG_W-1:0]  rdy_stg;
  } bypass_entry_t;

  typedef struct packed {
    logic                 hit;
    logic                 ready;
    logic [BT_DATA_W-1:0] data;
  } bypass_rdout_t;

endpackage

// File: rtl/bypass_tracker_if.sv
// Issue/read/result bus between the issue stage (master) and the tracker (slave).
interface bypass_tracker_if
  import bypass_tracker_pkg::*;
#(
  parameter int ISSUE_W = BT_ISSUE_W,
  parameter int STAGES  = BT_STAGES,
  parameter int REG_AW  = BT_REG_AW,
  parameter int DATA_W  = BT_DATA_W,
  parameter int STG_W   = $clog2(STAGES + 1)
);

  logic [ISSUE_W-1:0]                iss_valid_i;
  logic [ISSUE_W*REG_AW-1:0]         iss_rdst_i;
  logic [ISSUE_W*STG_W-1:0]          iss_rdy_stg_i;
  logic [STAGES*ISSUE_W*DATA_W-1:0]  stg_data_i;
  logic [ISSUE_W*2*REG_AW-1:0]       rd_addr_i;
  logic [ISSUE_W*2-1:0]              rd_hit_o;
  logic [ISSUE_W*2-1:0]              rd_ready_o;
  logic [ISSUE_W*2*DATA_W-1:0]       rd_data_o;

  modport master (
    output iss_valid_i, iss_rdst_i, iss_rdy_stg_i, stg_data_i, rd_addr_i,
    input  rd_hit_o, rd_ready_o, rd_data_o
  );

  modport slave (
    input  iss_valid_i, iss_rdst_i, iss_rdy_stg_i, stg_data_i, rd_addr_i,
    output rd_hit_o, rd_ready_o, rd_data_o
  );

endinterface

// File: rtl/bypass_tracker_lookup.sv
// Combinational priority match of one source address against all in-flight writers.
// Youngest stage wins; within a stage the higher slot (younger in program order) wins.
module bypass_tracker_lookup
  import bypass_tracker_pkg::*;
#(
  parameter int ISSUE_W = BT_ISSUE_W,
  parameter int STAGES  = BT_STAGES,
  parameter int REG_AW  = BT_REG_AW,
  parameter int DATA_W  = BT_DATA_W,
  parameter int STG_W   = $clog2(STAGES + 1)
) (
  input  logic [REG_AW-1:0]                addr_i,
  input  bypass_entry_t [STAGES*ISSUE_W-1:0] ent_i,
  input  logic [STAGES*ISSUE_W*DATA_W-1:0] data_i,
  output bypass_rdout_t                    rd_o
);

  // Scan oldest to youngest so the last match written is the youngest one.
  always_comb begin
    rd_o       = '0;
    rd_o.ready = 1'b1;
    for (int s = STAGES - 1; s >= 0; s--) begin
      for (int w = 0; w < ISSUE_W; w++) begin
        if ((addr_i != '0) && ent_i[s*ISSUE_W+w].valid &&
            (ent_i[s*ISSUE_W+w].rdst == addr_i)) begin
          if (STG_W'(s) >= ent_i[s*ISSUE_W+w].rdy_stg) begin
            rd_o.hit   = 1'b1;
            rd_o.ready = 1'b1;
            rd_o.data  = data_i[(s*ISSUE_W+w)*DATA_W +: DATA_W];
          end else begin
            rd_o.hit   = 1'b0;
            rd_o.ready = 1'b0;
            rd_o.data  = '0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/bypass_tracker.sv
// Operand-forwarding tracker: shift register of in-flight writer tags beside the
// issue stage, answering every source read with hit/ready/data and a hazard flag.
module bypass_tracker
  import bypass_tracker_pkg::*;
#(
  parameter int ISSUE_W     = BT_ISSUE_W,
  parameter int STAGES      = BT_STAGES,
  parameter int REG_AW      = BT_REG_AW,
  parameter int DATA_W      = BT_DATA_W,
  parameter int FLUSH_DEPTH = 2,
  parameter int STG_W       = $clog2(STAGES + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               stall_i,
  input  logic               flush_i,
  bypass_tracker_if.slave    bus,
  output logic               hazard_o,
  output logic [31:0]        stall_cnt_o
);

  localparam int NENT = STAGES * ISSUE_W;
  localparam int NRD  = ISSUE_W * 2;

  bypass_entry_t [NENT-1:0] ent_q, ent_d;
  logic [31:0]              cnt_q, cnt_d;

  bypass_rdout_t            rdout [NRD];
  logic [NRD-1:0]           hit_w, ready_w;
  logic [NRD*DATA_W-1:0]    data_w;

  // Entry e = stage*ISSUE_W + slot; a stall freezes every stage, flush still kills the young ones.
  always_comb begin
    ent_d = ent_q;
    if (!stall_i) begin
      for (int e = NENT - 1; e >= ISSUE_W; e--) begin
        ent_d[e] = ent_q[e-ISSUE_W];
      end
      for (int w = 0; w < ISSUE_W; w++) begin
        ent_d[w].valid   = bus.iss_valid_i[w] && (bus.iss_rdst_i[w*REG_AW +: REG_AW] != '0);
        ent_d[w].rdst    = bus.iss_rdst_i[w*REG_AW +: REG_AW];
        ent_d[w].rdy_stg = bus.iss_rdy_stg_i[w*STG_W +: STG_W];
      end
    end
    if (flush_i) begin
      for (int e = 0; e < FLUSH_DEPTH * ISSUE_W; e++) begin
        ent_d[e].valid = 1'b0;
      end
    end
  end

  assign cnt_d = (hazard_o && !stall_i && (cnt_q != '1)) ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    bypass_tracker_lookup #(
      .ISSUE_W (ISSUE_W),
      .STAGES  (STAGES),
      .REG_AW  (REG_AW),
      .DATA_W  (DATA_W),
      .STG_W   (STG_W)
    ) u_lookup (
      .addr_i (bus.rd_addr_i[p*REG_AW +: REG_AW]),
      .ent_i  (ent_q),
      .data_i (bus.stg_data_i),
      .rd_o   (rdout[p])
    );
  end

  always_comb begin
    hit_w   = '0;
    ready_w = '0;
    data_w  = '0;
    for (int p = 0; p < NRD; p++) begin
      hit_w[p]                   = rdout[p].hit;
      ready_w[p]                 = rdout[p].ready;
      data_w[p*DATA_W +: DATA_W] = rdout[p].data;
    end
  end

  assign bus.rd_hit_o   = hit_w;
  assign bus.rd_ready_o = ready_w;
  assign bus.rd_data_o  = data_w;
  assign hazard_o       = ~&ready_w;
  assign stall_cnt_o    = cnt_q;

endmodule

// File: doc/bypass_tracker.md
Name: bypass_tracker

Overview:
- Parametrised operand-forwarding unit for the N-issue in-order pipeline, successor to the fixed 2-wide, 5-stage issue-stage bypass.
- Owns an internal shift register of in-flight writer tags (rdst, ready-stage), advanced with the pipeline.
- Answers every issue-slot source read with hit / ready / data.
- Raises an issue hazard when a producer's result is not yet available.
- Sits beside the issue stage; the pipeline supplies per-stage result data.

Parameters:
- ISSUE_W, 2, issue slots per cycle.
- STAGES, 5, tracked stages after issue (0 = next E, STAGES-1 = last before regfile write).
- REG_AW, 5, register address width.
- DATA_W, 32, data width.
- FLUSH_DEPTH, 2, number of youngest stages cleared by flush_i (1..STAGES).
- STG_W, $clog2(STAGES+1), ready-stage field width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- stall_i  in  1  freeze all tracked stages.
- flush_i  in  1  clear stages 0..FLUSH_DEPTH-1.
- iss_valid_i  in  ISSUE_W  issuing slot writes a register.
- iss_rdst_i  in  ISSUE_W*REG_AW  destination per slot.
- iss_rdy_stg_i  in  ISSUE_W*STG_W  first stage index at which the result is valid; STAGES = never forwardable.
- stg_data_i  in  STAGES*ISSUE_W*DATA_W  result data per stage/slot.
- rd_addr_i  in  ISSUE_W*2*REG_AW  two source addresses per slot.
- rd_hit_o  out  ISSUE_W*2  forwarded value selected.
- rd_ready_o  out  ISSUE_W*2  operand obtainable this cycle.
- rd_data_o  out  ISSUE_W*2*DATA_W  forwarded data (0 when no hit).
- hazard_o  out  1  OR of ~rd_ready_o.
- stall_cnt_o  out  32  hazard cycles counter.

Behaviour:
- Entry per stage/slot: valid, rdst, rdy_stg. Reset: all entries invalid, stall_cnt_o = 0.
- Outputs are combinational from entries and inputs. With no valid entry: rd_hit_o = 0, rd_ready_o = all 1, rd_data_o = 0, hazard_o = 0.
- Advance on posedge when !stall_i: stage s+1 <= stage s; stage 0 <= issue inputs (valid = iss_valid_i && iss_rdst_i != 0). Entries leaving stage STAGES-1 are dropped.
- stall_i = 1: all stages hold. Issue inputs are ignored.
- flush_i = 1: stages 0..FLUSH_DEPTH-1 become invalid next cycle; older stages advance normally unless stalled.
  - flush + stall: flushed stages are invalidated, remaining stages hold.
  - flush also discards that cycle's issue inputs.
- Lookup per read port:
  - An address of 0 never matches.
  - Scan stage 0 first (youngest). Within a stage, the higher slot index wins (younger in program order).
  - The first valid match decides:
    - s >= rdy_stg: hit = 1, ready = 1, data = stg_data_i[s][slot].
    - otherwise: hit = 0, ready = 0, data = 0.
  - No match: regfile path, hit = 0, ready = 1.
- Dependencies within the same issue bundle are not this block's responsibility; the issuer resolves them.
- stall_cnt_o: increments when hazard_o && !stall_i and saturates at all-ones. flush does not clear it; only resetn does.
- Reset asserted mid-operation: entries cleared immediately and asynchronously; outputs fall to the idle values above.

Decomposition:
- Shared package (pipes): bypass_entry_t {valid, rdst, rdy_stg}, bypass_rdout_t {hit, ready, data}, and ready-stage constants RDY_ALU = 0, RDY_HILO = 1, RDY_MEM = 2, RDY_NEVER = STAGES.
- One sub-module, bypass_lookup: purely combinational priority match for one read port. Instantiated ISSUE_W*2 times.

Test Plan:
- Reset, then read r5 on all ports -> hit = 0, ready = 1, data = 0, hazard_o = 0, stall_cnt_o = 0.
- Issue slot0 rdst = 5, rdy = 0; next cycle drive stg_data[0][0] = 0x1234 and read r5 on slot1 src1 -> hit = 1, ready = 1, data = 0x1234.
- Issue load rdst = 7, rdy = 2:
  - cycles at stages 0 and 1: reading r7 gives ready = 0, hazard_o = 1, stall_cnt increments by 1 per cycle.
  - at stage 2 with stg_data = 0xBEEF: hit = 1, data = 0xBEEF.
- Same cycle, slot0 and slot1 both write r3, rdy = 0, data 0xA / 0xB -> read r3 returns 0xB. After a later single issue of r3 with data 0xC at stage 0 -> returns 0xC.
- Issue r9 at stage 0, assert flush_i with FLUSH_DEPTH = 2 -> r9 lookup misses next cycle. An r4 entry at stage 3 survives and advances to stage 4.
- Hold stall_i 3 cycles with r6 at stage 1 -> entry stays at stage 1 and stall_cnt_o is unchanged. Then pulse resetn low mid-stall -> all lookups miss and stall_cnt_o = 0.
